// File: rtl/trap_sequencer_pkg.sv
// Shared constants for the trap/return sequencer: instruction encodings,
// CSR addresses, mstatus bit positions, trap causes and FSM state encoding.
package trap_sequencer_pkg;

  localparam logic [31:0] INST_ECALL = 32'h0000_0073;
  localparam logic [31:0] INST_MRET  = 32'h3020_0073;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

  localparam logic [31:0] CAUSE_ECALL   = 32'd11;
  localparam logic [31:0] CAUSE_EXT_IRQ = 32'h8000_000B;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    W_MEPC    = 3'd1,
    W_MCAUSE  = 3'd2,
    W_MSTATUS = 3'd3,
    W_MRET    = 3'd4,
    JUMP      = 3'd5
  } state_t;

endpackage

// File: rtl/trap_sequencer.sv
// Trap/return sequencer: stalls decode, writes mepc/mcause/mstatus one per cycle,
// then pulses a redirect. External interrupts are taken only when TRAP_EXT_IRQ_EN is defined.
//
// state     | meaning
// IDLE      | waiting for ECALL / MRET / interrupt in decode
// W_MEPC    | writing trapping PC to mepc
// W_MCAUSE  | writing trap cause to mcause
// W_MSTATUS | stacking MIE into MPIE, clearing MIE, latching mtvec target
// W_MRET    | restoring MIE from MPIE, setting MPIE
// JUMP      | one-cycle redirect to pc_q
module trap_sequencer
  import trap_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int CSR_ADDR_WIDTH = 12
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [DATA_WIDTH-1:0]     inst_i,
  input  logic [ADDR_WIDTH-1:0]     inst_addr_i,
  input  logic                      irq_i,
  input  logic [DATA_WIDTH-1:0]     mstatus_i,
  input  logic [ADDR_WIDTH-1:0]     mtvec_i,
  input  logic [ADDR_WIDTH-1:0]     mepc_i,
  output logic                      csr_we_o,
  output logic [CSR_ADDR_WIDTH-1:0] csr_waddr_o,
  output logic [DATA_WIDTH-1:0]     csr_wdata_o,
  output logic                      hold_o,
  output logic                      int_enable_o,
  output logic [ADDR_WIDTH-1:0]     int_addr_o
);

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] cause_q, cause_d;
  logic                  is_ecall, is_mret, is_irq, trap_det;
  logic [1:0]            unused_mtvec_mode;

  assign is_ecall = (inst_i == DATA_WIDTH'(INST_ECALL));
  assign is_mret  = (inst_i == DATA_WIDTH'(INST_MRET));

`ifdef TRAP_EXT_IRQ_EN
  assign is_irq = irq_i & mstatus_i[MSTATUS_MIE];
`else
  logic unused_irq;
  assign unused_irq = irq_i;
  assign is_irq     = 1'b0;
`endif

  // Only direct-mode vectoring is supported, so the mode bits are dropped.
  assign unused_mtvec_mode = mtvec_i[1:0];

  assign trap_det = rst_i & (state == IDLE) & (is_ecall | is_mret | is_irq);
  assign hold_o   = (state != IDLE) | trap_det;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      pc_q    <= '0;
      cause_q <= '0;
    end else begin
      state   <= state_next;
      pc_q    <= pc_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_next   = state;
    pc_d         = pc_q;
    cause_d      = cause_q;
    csr_we_o     = 1'b0;
    csr_waddr_o  = '0;
    csr_wdata_o  = '0;
    int_enable_o = 1'b0;
    int_addr_o   = '0;
    case (state)
      IDLE: begin
        if (is_ecall) begin
          pc_d       = inst_addr_i;
          cause_d    = DATA_WIDTH'(CAUSE_ECALL);
          state_next = W_MEPC;
        end else if (is_mret) begin
          pc_d       = mepc_i;
          state_next = W_MRET;
        end else if (is_irq) begin
          pc_d       = inst_addr_i;
          cause_d    = DATA_WIDTH'(CAUSE_EXT_IRQ);
          state_next = W_MEPC;
        end
      end
      W_MEPC: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_ADDR_WIDTH'(CSR_MEPC);
        csr_wdata_o = DATA_WIDTH'(pc_q);
        state_next  = W_MCAUSE;
      end
      W_MCAUSE: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_ADDR_WIDTH'(CSR_MCAUSE);
        csr_wdata_o = cause_q;
        state_next  = W_MSTATUS;
      end
      W_MSTATUS: begin
        csr_we_o                  = 1'b1;
        csr_waddr_o               = CSR_ADDR_WIDTH'(CSR_MSTATUS);
        csr_wdata_o               = mstatus_i;
        csr_wdata_o[MSTATUS_MPIE] = mstatus_i[MSTATUS_MIE];
        csr_wdata_o[MSTATUS_MIE]  = 1'b0;
        pc_d                      = {mtvec_i[ADDR_WIDTH-1:2], 2'b00};
        state_next                = JUMP;
      end
      W_MRET: begin
        csr_we_o                  = 1'b1;
        csr_waddr_o               = CSR_ADDR_WIDTH'(CSR_MSTATUS);
        csr_wdata_o               = mstatus_i;
        csr_wdata_o[MSTATUS_MIE]  = mstatus_i[MSTATUS_MPIE];
        csr_wdata_o[MSTATUS_MPIE] = 1'b1;
        state_next                = JUMP;
      end
      JUMP: begin
        int_enable_o = 1'b1;
        int_addr_o   = pc_q;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// Scoreboard bench for trap_sequencer: directed and random traps; expected CSR
// writes and redirects are queued by a reference model and checked by a monitor.
module tb_trap_sequencer;

  localparam logic [31:0] ECALL = 32'h0000_0073;
  localparam logic [31:0] MRET  = 32'h3020_0073;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef struct {
    int          cyc;
    bit          is_jump;
    logic [11:0] addr;
    logic [31:0] data;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] inst = NOP;
  logic [31:0] inst_addr = '0;
  logic        irq = 1'b0;
  logic [31:0] mstatus = '0;
  logic [31:0] mtvec = '0;
  logic [31:0] mepc = '0;
  logic        csr_we, hold, int_en;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata, int_addr;

  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  ev_t q[$];

  trap_sequencer dut (
    .clk_i(clk), .rst_i(rst_n), .inst_i(inst), .inst_addr_i(inst_addr),
    .irq_i(irq), .mstatus_i(mstatus), .mtvec_i(mtvec), .mepc_i(mepc),
    .csr_we_o(csr_we), .csr_waddr_o(csr_waddr), .csr_wdata_o(csr_wdata),
    .hold_o(hold), .int_enable_o(int_en), .int_addr_o(int_addr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: queue the architectural effects of whatever decode presents.
  task automatic model(input logic [31:0] i, input logic [31:0] a, input bit rq,
                       input logic [31:0] ms, input logic [31:0] tv, input logic [31:0] ep,
                       input int c0, output int n);
    bit          mie, mpie, take_irq;
    logic [31:0] cause;
    mie  = ms[3];
    mpie = ms[7];
`ifdef TRAP_EXT_IRQ_EN
    take_irq = rq && mie;
`else
    take_irq = 1'b0;
`endif
    n = 0;
    if (i == ECALL || (i != MRET && take_irq)) begin
      cause = (i == ECALL) ? 32'd11 : 32'h8000_000B;
      q.push_back('{c0 + 1, 1'b0, 12'h341, a});
      q.push_back('{c0 + 2, 1'b0, 12'h342, cause});
      q.push_back('{c0 + 3, 1'b0, 12'h300, (ms & ~32'h88) | (32'(mie) << 7)});
      q.push_back('{c0 + 4, 1'b1, 12'h000, tv & ~32'h3});
      n = 4;
    end else if (i == MRET) begin
      q.push_back('{c0 + 1, 1'b0, 12'h300, (ms & ~32'h88) | 32'h80 | (32'(mpie) << 3)});
      q.push_back('{c0 + 2, 1'b1, 12'h000, ep});
      n = 2;
    end
  endtask

  function automatic logic [31:0] noise_inst();
    case ($urandom_range(0, 2))
      0:       return ECALL;
      1:       return MRET;
      default: return $urandom;
    endcase
  endfunction

  // Called just after a rising edge; returns just after the edge that follows the sequence.
  task automatic trans(input logic [31:0] i, input logic [31:0] a, input bit rq,
                       input logic [31:0] ms, input logic [31:0] tv, input logic [31:0] ep);
    int n;
    inst = i; inst_addr = a; irq = rq; mstatus = ms; mtvec = tv; mepc = ep;
    @(negedge clk);
    model(i, a, rq, ms, tv, ep, cyc, n);
    chk("hold_detect", 32'(hold), 32'(n > 0));
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      inst = noise_inst(); irq = 1'($urandom); inst_addr = $urandom;
      @(negedge clk);
      chk("hold_busy", 32'(hold), 32'd1);
    end
    @(posedge clk); #1;
    inst = NOP; irq = 1'b0;
  endtask

  // Monitor: every write or redirect must match the head of the scoreboard.
  always @(negedge clk) begin
    ev_t e;
    if (csr_we && int_en) chk("we_and_redirect", 32'd1, 32'd0);
    if (!csr_we) chk("idle_wdata", csr_wdata | 32'(csr_waddr), 32'd0);
    if (!int_en) chk("idle_int_addr", int_addr, 32'd0);
    if (csr_we || int_en) begin
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_output we=%b waddr=%h wdata=%h redirect=%b addr=%h required=none",
                 csr_we, csr_waddr, csr_wdata, int_en, int_addr);
      end else begin
        e = q.pop_front();
        chk("event_cycle", 32'(cyc), 32'(e.cyc));
        chk("event_kind", 32'(int_en), 32'(e.is_jump));
        if (e.is_jump) chk("redirect_addr", int_addr, e.data);
        else begin
          chk("csr_waddr", 32'(csr_waddr), 32'(e.addr));
          chk("csr_wdata", csr_wdata, e.data);
        end
      end
    end
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_hold", 32'(hold), 32'd0);
    chk("reset_we", 32'(csr_we), 32'd0);
    chk("reset_redirect", 32'(int_en), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    trans(ECALL, 32'h40, 1'b0, 32'h8, 32'h100, 32'h0);
    trans(MRET, 32'h48, 1'b0, 32'h80, 32'h100, 32'h44);
    // ECALL with a pending interrupt: ECALL first, interrupt once back in IDLE.
    trans(ECALL, 32'h80, 1'b1, 32'h8, 32'h200, 32'h0);
    trans(NOP, 32'h84, 1'b1, 32'h8, 32'h200, 32'h0);
    trans(NOP, 32'h88, 1'b1, 32'h0, 32'h200, 32'h0);

    // Reset while writing mcause: mstatus write and redirect must never appear.
    inst = ECALL; inst_addr = 32'h60; mstatus = 32'h8; mtvec = 32'h300; irq = 1'b0;
    @(negedge clk);
    model(ECALL, 32'h60, 1'b0, 32'h8, 32'h300, 32'h0, cyc, n);
    void'(q.pop_back());
    void'(q.pop_back());
    @(posedge clk); #1;
    inst = ECALL;
    @(posedge clk); #1;
    inst = NOP; rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_hold", 32'(hold), 32'd0);
    chk("abort_we", 32'(csr_we), 32'd0);
    chk("abort_redirect", 32'(int_en) | int_addr, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    for (int r = 0; r < 300; r++) begin
      logic [31:0] ri;
      case ($urandom_range(0, 3))
        0:       ri = ECALL;
        1:       ri = MRET;
        default: ri = $urandom;
      endcase
      trans(ri, $urandom & ~32'h3, 1'($urandom), $urandom, $urandom, $urandom);
    end

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
